// File: rtl/coconut_reconstructor.sv
// coconut_reconstructor: backward search for the smallest valid coconut pile, streamed out night by night
module coconut_reconstructor #(
  parameter int SAILORS = 5,
  parameter int WIDTH = 32,
  parameter int MAX_Q = 65535
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             found,
  output logic             fail,
  output logic [WIDTH-1:0] orig_pile,
  output logic [WIDTH-1:0] morning_share,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_sailor,
  output logic [WIDTH-1:0] out_share,
  output logic [WIDTH-1:0] out_pile_after,
  output logic             out_last
);
  localparam int EW = WIDTH + 9;
  localparam int IW = $clog2(SAILORS);
  typedef enum logic [2:0] {IDLE, INIT, STEP, NEXT, REPORT} state_t;
  state_t state_q;
  logic [WIDTH-1:0] q_q, p_q;
  logic [7:0] idx_q, rp_q;
  logic [WIDTH-1:0] share_q [SAILORS];
  logic [WIDTH-1:0] pile_q [SAILORS];
  logic [WIDTH-1:0] s_d;
  logic divisible_d;
  logic [EW-1:0] init_d, step_d;
  // extra headroom bits make any overflow past WIDTH visible
  always_comb begin
    s_d = p_q / WIDTH'(SAILORS - 1);
    divisible_d = p_q % WIDTH'(SAILORS - 1) == '0;
    init_d = EW'(q_q) * EW'(SAILORS) + EW'(1);
    step_d = EW'(s_d) * EW'(SAILORS) + EW'(1);
  end
  assign out_valid = state_q == REPORT;
  assign out_last = out_valid && rp_q == 8'(SAILORS - 1);
  assign out_sailor = out_valid ? rp_q + 8'd1 : '0;
  assign out_share = out_valid ? share_q[IW'(rp_q)] : '0;
  assign out_pile_after = out_valid ? pile_q[IW'(rp_q)] : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      q_q <= '0;
      p_q <= '0;
      idx_q <= '0;
      rp_q <= '0;
      busy <= 1'b0;
      found <= 1'b0;
      fail <= 1'b0;
      orig_pile <= '0;
      morning_share <= '0;
    end else begin
      found <= 1'b0;
      fail <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          q_q <= '0;
          busy <= 1'b1;
          state_q <= INIT;
        end
        INIT: if (|init_d[EW-1:WIDTH]) begin
          fail <= 1'b1;
          busy <= 1'b0;
          state_q <= IDLE;
        end else begin
          p_q <= WIDTH'(init_d);
          idx_q <= 8'(SAILORS);
          state_q <= STEP;
        end
        STEP: if (!divisible_d) state_q <= NEXT;
        else begin
          share_q[IW'(idx_q - 8'd1)] <= s_d;
          pile_q[IW'(idx_q - 8'd1)] <= p_q;
          p_q <= WIDTH'(step_d);
          idx_q <= idx_q - 8'd1;
          if (|step_d[EW-1:WIDTH]) begin
            fail <= 1'b1;
            busy <= 1'b0;
            state_q <= IDLE;
          end else if (idx_q == 8'd1) begin
            orig_pile <= WIDTH'(step_d);
            morning_share <= q_q;
            found <= 1'b1;
            rp_q <= '0;
            state_q <= REPORT;
          end
        end
        NEXT: if (q_q == WIDTH'(MAX_Q)) begin
          fail <= 1'b1;
          busy <= 1'b0;
          state_q <= IDLE;
        end else begin
          q_q <= q_q + 1'b1;
          state_q <= INIT;
        end
        REPORT: if (out_ready) begin
          if (rp_q == 8'(SAILORS - 1)) begin
            busy <= 1'b0;
            state_q <= IDLE;
          end else rp_q <= rp_q + 8'd1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_coconut_reconstructor.sv
// tb_coconut_reconstructor: scoreboarded scenarios across four parameterisations of the reconstructor
module tb_coconut_reconstructor;
  typedef struct { int sailor; int share; int pile; bit last; } rec_t;
  typedef struct { int d; bit stall; int s; int orig; int morn; } row_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ready5 = 1'b1;
  bit stall = 1'b0;
  logic start_v [4];
  logic busy_v [4], found_v [4], fail_v [4], valid_v [4], last_v [4];
  logic [7:0] sailor_v [4];
  logic [31:0] orig_v [3], morn_v [3], share_v [3], pile_v [3];
  logic [11:0] orig_w, morn_w, share_w, pile_w;
  rec_t exp_q [$];
  longint share_sum;
  bit seen_found_q, seen_valid_q, seen_found_w;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;

  coconut_reconstructor dut5 (.clk(clk), .rst(rst), .start(start_v[0]), .busy(busy_v[0]), .found(found_v[0]),
    .fail(fail_v[0]), .orig_pile(orig_v[0]), .morning_share(morn_v[0]), .out_valid(valid_v[0]), .out_ready(ready5),
    .out_sailor(sailor_v[0]), .out_share(share_v[0]), .out_pile_after(pile_v[0]), .out_last(last_v[0]));
  coconut_reconstructor #(.SAILORS(3)) dut3 (.clk(clk), .rst(rst), .start(start_v[1]), .busy(busy_v[1]),
    .found(found_v[1]), .fail(fail_v[1]), .orig_pile(orig_v[1]), .morning_share(morn_v[1]), .out_valid(valid_v[1]),
    .out_ready(1'b1), .out_sailor(sailor_v[1]), .out_share(share_v[1]), .out_pile_after(pile_v[1]), .out_last(last_v[1]));
  coconut_reconstructor #(.MAX_Q(1000)) dutq (.clk(clk), .rst(rst), .start(start_v[2]), .busy(busy_v[2]),
    .found(found_v[2]), .fail(fail_v[2]), .orig_pile(orig_v[2]), .morning_share(morn_v[2]), .out_valid(valid_v[2]),
    .out_ready(1'b1), .out_sailor(sailor_v[2]), .out_share(share_v[2]), .out_pile_after(pile_v[2]), .out_last(last_v[2]));
  coconut_reconstructor #(.WIDTH(12)) dutw (.clk(clk), .rst(rst), .start(start_v[3]), .busy(busy_v[3]),
    .found(found_v[3]), .fail(fail_v[3]), .orig_pile(orig_w), .morning_share(morn_w), .out_valid(valid_v[3]),
    .out_ready(1'b1), .out_sailor(sailor_v[3]), .out_share(share_w), .out_pile_after(pile_w), .out_last(last_v[3]));

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic pulse_start(input int d);
    @(posedge clk); #1 start_v[d] = 1'b1;
    @(posedge clk); #1 start_v[d] = 1'b0;
  endtask

  task automatic wait_hi(input int d, input bit on_fail, output int cyc);
    cyc = 0;
    while (!(on_fail ? fail_v[d] : found_v[d])) begin
      if (cyc == 30000) begin
        cyc = -1;
        return;
      end
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic wait_idle(input int d);
    int n;
    n = 0;
    while (busy_v[d] && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("busy_falls", busy_v[d], 0);
  endtask

  initial begin
    int k;
    k = 0;
    forever begin
      @(posedge clk); #1;
      ready5 = stall ? (k % 3 == 0) : 1'b1;
      k++;
    end
  end

  initial begin : mon
    rec_t e;
    bit stalled_prev;
    logic [72:0] held;
    stalled_prev = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 4; d++)
        if (found_v[d] || fail_v[d]) check("found_fail_exclusive", found_v[d] && fail_v[d], 0);
      if (found_v[2]) seen_found_q = 1'b1;
      if (valid_v[2]) seen_valid_q = 1'b1;
      if (found_v[3] || valid_v[3]) seen_found_w = 1'b1;
      if (stalled_prev) check("stall_hold", {valid_v[0], sailor_v[0], share_v[0], pile_v[0]} == held, 1);
      stalled_prev = valid_v[0] && !ready5;
      held = {valid_v[0], sailor_v[0], share_v[0], pile_v[0]};
      for (int d = 0; d < 2; d++)
        if (valid_v[d] && (d != 0 || ready5)) begin
          if (exp_q.size() == 0) check("unexpected_record", sailor_v[d], 0);
          else begin
            e = exp_q.pop_front();
            check("rec_sailor", sailor_v[d], e.sailor);
            check("rec_share", share_v[d], e.share);
            check("rec_pile", pile_v[d], e.pile);
            check("rec_last", last_v[d], e.last);
            share_sum += share_v[d];
          end
        end
    end
  end

  initial begin
    rec_t r5 [5];
    rec_t r3 [3];
    row_t rows [3];
    int cyc, t5;
    r5 = '{'{1, 3124, 12496, 0}, '{2, 2499, 9996, 0}, '{3, 1999, 7996, 0}, '{4, 1599, 6396, 0}, '{5, 1279, 5116, 1}};
    r3 = '{'{1, 26, 52, 0}, '{2, 17, 34, 0}, '{3, 11, 22, 1}};
    rows = '{'{0, 0, 5, 15621, 1023}, '{1, 0, 3, 79, 7}, '{0, 1, 5, 15621, 1023}};
    t5 = 0;
    for (int d = 0; d < 4; d++) start_v[d] = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", busy_v[0], 0);
    check("reset_valid", valid_v[0], 0);
    check("reset_orig", orig_v[0], 0);
    check("reset_sailor", sailor_v[0], 0);
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      int d, s;
      d = rows[i].d;
      s = rows[i].s;
      stall = rows[i].stall;
      share_sum = 0;
      for (int j = 0; j < s; j++)
        if (s == 5) exp_q.push_back(r5[j]);
        else exp_q.push_back(r3[j]);
      pulse_start(d);
      wait_hi(d, 0, cyc);
      check("found_in_time", cyc >= 0, 1);
      if (i == 0) t5 = cyc;
      check("orig_pile", orig_v[d], rows[i].orig);
      check("morning_share", morn_v[d], rows[i].morn);
      check("valid_with_found", valid_v[d], 1);
      @(negedge clk);
      check("found_one_cycle", found_v[d], 0);
      wait_idle(d);
      check("records_drained", exp_q.size(), 0);
      check("identity", orig_v[d], share_sum + longint'(morn_v[d]) * s + s + 1);
      stall = 1'b0;
    end
    seen_found_q = 1'b0;
    seen_valid_q = 1'b0;
    pulse_start(2);
    wait_hi(2, 1, cyc);
    check("maxq_fail", cyc >= 0, 1);
    check("maxq_busy_low_at_fail", busy_v[2], 0);
    check("maxq_no_found", seen_found_q, 0);
    check("maxq_no_valid", seen_valid_q, 0);
    @(negedge clk);
    check("maxq_fail_one_cycle", fail_v[2], 0);
    seen_found_w = 1'b0;
    pulse_start(3);
    wait_hi(3, 1, cyc);
    check("width_overflow_fail", cyc >= 0, 1);
    check("width_no_found", seen_found_w, 0);
    check("width_orig_zero", orig_w, 0);
    pulse_start(0);
    repeat (500) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy_v[0], 0);
    check("rst_found_fail", {found_v[0], fail_v[0]}, 0);
    check("rst_orig", orig_v[0], 0);
    check("rst_morn", morn_v[0], 0);
    check("rst_out", {valid_v[0], last_v[0], sailor_v[0], share_v[0], pile_v[0]}, 0);
    @(posedge clk); #1 rst = 1'b0;
    share_sum = 0;
    for (int j = 0; j < 5; j++) exp_q.push_back(r5[j]);
    pulse_start(0);
    fork
      wait_hi(0, 0, cyc);
      begin
        repeat (100) @(posedge clk);
        pulse_start(0);
      end
    join
    check("restart_latency", cyc, t5);
    check("restart_orig", orig_v[0], 15621);
    wait_idle(0);
    check("restart_drained", exp_q.size(), 0);
    check("restart_identity", orig_v[0], share_sum + longint'(morn_v[0]) * 5 + 6);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
